// File: rtl/icap_boot_ctrl.sv
// icap_boot_ctrl: debounced button / DFU detach triggered ICAPE2 IPROG warm-boot sequencer
module icap_boot_ctrl #(
    parameter logic [31:0] WBSTAR_ADDR     = 32'h0200_0000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] HOLDOFF_CYCLES  = 16'hffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_button,
    input  logic        dfu_detach,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, ARM, SEND, FINISH, DONE} state_t;
    state_t      state, state_n;
    logic [1:0]  btn_sync;
    logic [15:0] deb_cnt, holdoff;
    logic        armed, pending, button_trig;
    logic [2:0]  idx, idx_n;
    logic [31:0] word, word_sw;
    assign button_trig = armed && btn_sync[1] && deb_cnt == DEBOUNCE_CYCLES - 16'd1;
    // two-flop synchronizer for the raw button
    always_ff @(posedge clk or negedge reset)
        if (!reset) btn_sync <= 2'b00;
        else btn_sync <= {btn_sync[0], boot_button};
    // count stable-high cycles; fire once, re-arm only after a low cycle
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            deb_cnt <= 16'd0;
            armed   <= 1'b1;
        end else if (!btn_sync[1]) begin
            deb_cnt <= 16'd0;
            armed   <= 1'b1;
        end else if (armed) begin
            deb_cnt <= deb_cnt + 16'd1;
            armed   <= !button_trig;
        end
    // post-reset holdoff, saturating at zero
    always_ff @(posedge clk or negedge reset)
        if (!reset) holdoff <= HOLDOFF_CYCLES;
        else if (holdoff != 16'd0) holdoff <= holdoff - 16'd1;
    // request latch: set only while idle, cleared when the sequence arms
    always_ff @(posedge clk or negedge reset)
        if (!reset) pending <= 1'b0;
        else pending <= (state_n == ARM) ? 1'b0 : pending | (state == IDLE && (button_trig || dfu_detach));
    // next-state and word index
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE:    if (pending && holdoff == 16'd0) state_n = ARM;
            ARM:     begin state_n = SEND; idx_n = 3'd0; end
            SEND:    begin idx_n = idx + 3'd1; if (idx == 3'd7) state_n = FINISH; end
            FINISH:  state_n = DONE;
            default: state_n = DONE;
        endcase
    end
    // IPROG command stream, selected by the upcoming word index
    always_comb begin
        word = 32'h0;
        case (idx_n)
            3'd0: word = 32'hFFFF_FFFF;
            3'd1: word = 32'hAA99_5566;
            3'd2: word = 32'h2000_0000;
            3'd3: word = 32'h3002_0001;
            3'd4: word = WBSTAR_ADDR;
            3'd5: word = 32'h3000_8001;
            3'd6: word = 32'h0000_000F;
            3'd7: word = 32'h2000_0000;
        endcase
    end
    for (genvar b = 0; b < 4; b++) begin : g_byte
        for (genvar k = 0; k < 8; k++) begin : g_bit
            assign word_sw[8*b+k] = word[8*b+7-k];
        end
    end
    // state register and outputs registered from the next state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
            icap_i     <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            icap_csib  <= state_n != SEND;
            icap_rdwrb <= state_n == IDLE || state_n == DONE;
            icap_i     <= (state_n == SEND) ? word_sw : 32'h0;
            busy       <= state_n == ARM || state_n == SEND || state_n == FINISH;
            done       <= state_n == DONE;
        end
endmodule

// File: tb/tb_icap_boot_ctrl.sv
// tb_icap_boot_ctrl: vector table, directed corner cases and randomized requests against a timeline model
module tb_icap_boot_ctrl;
    localparam int H = 16;
    localparam int D = 8;
    typedef struct { int off; logic [35:0] exp; } vec_t;
    logic clk = 1'b0, reset = 1'b0, boot_button = 1'b0, dfu_detach = 1'b0;
    logic csib, rdwrb, busy, done, csib2, rdwrb2, busy2, done2;
    logic [31:0] data, data2;
    int checks = 0, errors = 0;
    int n, req, run, first_busy, low_cnt;
    bit armd, h1, h2;
    logic [31:0] swp [8];
    vec_t tbl [12];

    always #5 clk = ~clk;

    icap_boot_ctrl #(.WBSTAR_ADDR(32'h0200_0000), .DEBOUNCE_CYCLES(16'd8), .HOLDOFF_CYCLES(16'd16)) dut (
        .clk(clk), .reset(reset), .boot_button(boot_button), .dfu_detach(dfu_detach),
        .icap_csib(csib), .icap_rdwrb(rdwrb), .icap_i(data), .busy(busy), .done(done));

    icap_boot_ctrl #(.WBSTAR_ADDR(32'h0040_0000), .DEBOUNCE_CYCLES(16'd8), .HOLDOFF_CYCLES(16'd16)) dut2 (
        .clk(clk), .reset(reset), .boot_button(boot_button), .dfu_detach(dfu_detach),
        .icap_csib(csib2), .icap_rdwrb(rdwrb2), .icap_i(data2), .busy(busy2), .done(done2));

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got %h want %h", name, n, got, exp);
        end
    endtask

    // expected {csib, rdwrb, busy, done, icap_i} at edge e, from the first request edge
    function automatic logic [35:0] model(input int e);
        int a;
        a = (req < 0) ? -1 : ((req > H) ? req : H) + 1;
        if (a < 0 || e < a) return {4'b1100, 32'h0};
        if (e == a) return {4'b1010, 32'h0};
        if (e <= a + 8) return {4'b0010, swp[e-a-1]};
        if (e == a + 9) return {4'b1010, 32'h0};
        return {4'b1101, 32'h0};
    endfunction

    task automatic tick;
        bit cb, cd, s;
        cb = boot_button;
        cd = dfu_detach;
        @(posedge clk);
        #1;
        n++;
        s  = h2;
        h2 = h1;
        h1 = cb;
        if (!s) begin
            run  = 0;
            armd = 1'b1;
        end else begin
            run++;
            if (armd && run == D) begin
                armd = 1'b0;
                if (req < 0) req = n;
            end
        end
        if (cd && req < 0) req = n;
        if (busy && first_busy < 0) first_busy = n;
        if (!csib) low_cnt++;
        chk("model", {csib, rdwrb, busy, done, data}, model(n));
    endtask

    task automatic do_reset;
        reset       = 1'b0;
        boot_button = 1'b0;
        dfu_detach  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        n          = 0;
        req        = -1;
        run        = 0;
        armd       = 1'b1;
        h1         = 1'b0;
        h2         = 1'b0;
        first_busy = -1;
        low_cnt    = 0;
    endtask

    task automatic pulse_dfu_at(input int e);
        while (n < e - 1) tick();
        dfu_detach = 1'b1;
        tick();
        dfu_detach = 1'b0;
    endtask

    initial begin
        swp = '{32'hFFFF_FFFF, 32'h5599_AA66, 32'h0400_0000, 32'h0C40_0080,
                32'h4000_0000, 32'h0C00_0180, 32'h0000_00F0, 32'h0400_0000};
        tbl[0]  = '{-1, {4'b1100, 32'h0000_0000}};
        tbl[1]  = '{0,  {4'b1010, 32'h0000_0000}};
        tbl[2]  = '{1,  {4'b0010, 32'hFFFF_FFFF}};
        tbl[3]  = '{2,  {4'b0010, 32'h5599_AA66}};
        tbl[4]  = '{3,  {4'b0010, 32'h0400_0000}};
        tbl[5]  = '{4,  {4'b0010, 32'h0C40_0080}};
        tbl[6]  = '{5,  {4'b0010, 32'h4000_0000}};
        tbl[7]  = '{6,  {4'b0010, 32'h0C00_0180}};
        tbl[8]  = '{7,  {4'b0010, 32'h0000_00F0}};
        tbl[9]  = '{8,  {4'b0010, 32'h0400_0000}};
        tbl[10] = '{9,  {4'b1010, 32'h0000_0000}};
        tbl[11] = '{10, {4'b1101, 32'h0000_0000}};

        do_reset();
        chk("reset_state", {csib, rdwrb, busy, done, data}, {4'b1100, 32'h0});

        pulse_dfu_at(100);
        for (int i = 0; i < 12; i++) begin
            while (n < 101 + tbl[i].off) tick();
            chk($sformatf("vec%0d", i), {csib, rdwrb, busy, done, data}, tbl[i].exp);
            if (tbl[i].off == 5) chk("wbstar_alt", {4'h0, data2}, {4'h0, 32'h0002_0000});
        end
        repeat (20) tick();
        chk("done_sticky", {35'h0, done}, 36'h1);
        chk("low_cnt_030", low_cnt, 8);

        do_reset();
        while (n < 30) tick();
        boot_button = 1'b1;
        repeat (7) tick();
        boot_button = 1'b0;
        repeat (5) tick();
        boot_button = 1'b1;
        repeat (20) tick();
        boot_button = 1'b0;
        repeat (30) tick();
        chk("btn_start", first_busy, 53);
        chk("btn_low_cnt", low_cnt, 8);

        do_reset();
        pulse_dfu_at(3);
        repeat (40) tick();
        chk("holdoff_start", first_busy, 17);
        chk("holdoff_low_cnt", low_cnt, 8);

        do_reset();
        while (n < 20) tick();
        boot_button = 1'b1;
        pulse_dfu_at(30);
        boot_button = 1'b0;
        tick();
        boot_button = 1'b1;
        pulse_dfu_at(34);
        while (n < 80) tick();
        chk("dual_start", first_busy, 31);
        chk("dual_low_cnt", low_cnt, 8);

        do_reset();
        pulse_dfu_at(20);
        while (n < 25) tick();
        #2 reset = 1'b0;
        #1 chk("reset_mid_send", {csib, rdwrb, busy, done, data}, {4'b1100, 32'h0});
        do_reset();
        repeat (100) tick();
        chk("post_reset_idle", low_cnt, 0);
        chk("post_reset_busy", first_busy, -1);

        for (int it = 0; it < 24; it++) begin
            int dens;
            do_reset();
            dens = $urandom_range(0, 2);
            repeat (75) begin
                dfu_detach = (dens == 2) ? ($urandom_range(0, 39) == 0) : 1'b0;
                if (dens != 0 && $urandom_range(0, 5) == 0) boot_button = ~boot_button;
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
